// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation of a hi/lo pair, either per half
// or across the joined double-width value (link=1).
module mdu_sign_fix
    import mdu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] x_hi,
    input  logic [WIDTH-1:0] x_lo,
    input  logic             neg_hi,
    input  logic             neg_lo,
    input  logic             link,
    output logic [WIDTH-1:0] y_hi,
    output logic [WIDTH-1:0] y_lo
);

    logic [2*WIDTH-1:0] pair;
    logic [2*WIDTH-1:0] pair_n;

    always_comb begin
        pair   = {x_hi, x_lo};
        pair_n = -pair;
        y_hi   = x_hi;
        y_lo   = x_lo;
        if (link) begin
            if (neg_hi) begin
                y_hi = pair_n[2*WIDTH-1:WIDTH];
                y_lo = pair_n[WIDTH-1:0];
            end
        end else begin
            if (neg_hi) y_hi = -x_hi;
            if (neg_lo) y_lo = -x_lo;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: shift-add multiply and restoring
// divide, one bit per cycle, producing the HI/LO result pair.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state, state_n;
    op_e              op_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] p_hi, p_lo, opd;
    logic             s_a, s_d;
    logic             load, fin, dz;

    logic             sgn_in, div_q;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   m_sum, d_shift, d_diff;
    logic [WIDTH-1:0] nx_hi, nx_lo;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign sgn_in = ~op[0];
    assign div_q  = op_q inside {OP_DIV, OP_DIVU};

    mdu_sign_fix #(.WIDTH(WIDTH)) u_pre (
        .x_hi   (a),
        .x_lo   (b),
        .neg_hi (sgn_in & a[WIDTH-1]),
        .neg_lo (sgn_in & b[WIDTH-1]),
        .link   (1'b0),
        .y_hi   (abs_a),
        .y_lo   (abs_b)
    );

    // p_hi is the product upper half / partial remainder, p_lo the
    // multiplier / quotient being shifted in.
    always_comb begin
        m_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opd} : '0);
        d_shift = {p_hi, p_lo[WIDTH-1]};
        d_diff  = d_shift - {1'b0, opd};
        nx_hi   = m_sum[WIDTH:1];
        nx_lo   = {m_sum[0], p_lo[WIDTH-1:1]};
        if (div_q) begin
            nx_hi = d_diff[WIDTH] ? d_shift[WIDTH-1:0] : d_diff[WIDTH-1:0];
            nx_lo = {p_lo[WIDTH-2:0], ~d_diff[WIDTH]};
        end
    end

    mdu_sign_fix #(.WIDTH(WIDTH)) u_post (
        .x_hi   (nx_hi),
        .x_lo   (nx_lo),
        .neg_hi (div_q ? s_a : s_d),
        .neg_lo (s_d),
        .link   (~div_q),
        .y_hi   (res_hi),
        .y_lo   (res_lo)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        fin     = 1'b0;
        dz      = 1'b0;
        unique case (state)
            CALC: begin
                if (cnt == CW'(1)) begin
                    state_n = DONE;
                    fin     = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                if (start) begin
                    if (op[1] && b == '0) begin
                        state_n = DONE;
                        dz      = 1'b1;
                    end else begin
                        state_n = CALC;
                        load    = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q     <= OP_MULT;
            cnt      <= '0;
            p_hi     <= '0;
            p_lo     <= '0;
            opd      <= '0;
            s_a      <= 1'b0;
            s_d      <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            div_zero <= 1'b0;
            if (load) begin
                op_q <= op_e'(op);
                cnt  <= CW'(WIDTH);
                p_hi <= '0;
                p_lo <= op[1] ? abs_a : abs_b;
                opd  <= op[1] ? abs_b : abs_a;
                s_a  <= sgn_in & a[WIDTH-1];
                s_d  <= sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]);
            end else if (state == CALC) begin
                p_hi <= nx_hi;
                p_lo <= nx_lo;
                cnt  <= cnt - CW'(1);
                if (fin) begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
            end
            if (dz) begin
                hi       <= a;
                lo       <= '1;
                div_zero <= 1'b1;
            end
        end
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

endmodule
